// File: rtl/tx_data_fifo_ctrl.sv
// tx_data_fifo_ctrl
// Single-clock FIFO controller for the TX data RAM (simple-dual-port,
// 1-cycle read latency). It generates RAM addresses and enables, tracks
// occupancy, and presents a first-word-fall-through head through a
// 2-entry output buffer that hides the RAM read latency.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    push request and data
//   full, almost_full RAM occupancy flags (registered)
//   rd_en             pop request, honoured only while rd_valid
//   rd_data, rd_valid FWFT head word and its valid flag (registered)
//   almost_empty      total level <= AE_THRESH (registered)
//   level             total words held: RAM + in-flight + output buffer
//   ovf, udf          one-cycle pulses for dropped pushes / ignored pops
//   ram_*             RAM write port, read port and output reset
module tx_data_fifo_ctrl #(
   parameter int unsigned AW        = 10,
   parameter int unsigned DW        = 32,
   parameter int unsigned AF_THRESH = 1020,
   parameter int unsigned AE_THRESH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   output logic          almost_full,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          almost_empty,
   output logic [AW:0]   level,
   output logic          ovf,
   output logic          udf,
   output logic [AW-1:0] ram_aw,
   output logic [DW-1:0] ram_dw,
   output logic          ram_cew,
   output logic [AW-1:0] ram_ar,
   output logic          ram_cer,
   output logic          ram_rstr,
   input  logic [DW-1:0] ram_qr
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = AW + 1;

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] ram_cnt_q, ram_cnt_d;
   logic [CW-1:0] level_q, level_d;
   logic [1:0]    ob_cnt_q, ob_cnt_d;
   logic          inflight_q, inflight_d;
   logic [DW-1:0] ob0_q, ob0_d;
   logic [DW-1:0] ob1_q, ob1_d;
   logic          rd_valid_q, rd_valid_d;
   logic          full_q, full_d;
   logic          af_q, af_d;
   logic          ae_q, ae_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;

   logic          push_acc;
   logic          pop;
   logic          issue;
   logic [1:0]    cnt_after_pop;

   // Request qualification, RAM read scheduling and next-state computation
   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      ob0_d      = ob0_q;
      ob1_d      = ob1_q;

      push_acc   = wr_en && !full_q && !rst;
      pop        = rd_en && (ob_cnt_q != 2'd0) && !rst;
      // Read only if the word will have a buffer slot when it returns
      issue      = !rst && (ram_cnt_q != '0) &&
                   ((3'(ob_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

      if (push_acc) wp_d = wp_q + AW'(1);
      if (issue)    rp_d = rp_q + AW'(1);

      ram_cnt_d  = ram_cnt_q + CW'(push_acc) - CW'(issue);
      level_d    = level_q + CW'(push_acc) - CW'(pop);

      // Output buffer: shift on pop, then land returning RAM data at the tail
      cnt_after_pop = ob_cnt_q - 2'(pop);
      if (pop) ob0_d = ob1_q;
      if (inflight_q) begin
         if (cnt_after_pop == 2'd0) ob0_d = ram_qr;
         else                       ob1_d = ram_qr;
      end
      ob_cnt_d   = cnt_after_pop + 2'(inflight_q);
      inflight_d = issue;
      rd_valid_d = (ob_cnt_d != 2'd0);

      full_d     = (ram_cnt_d == CW'(DEPTH));
      af_d       = (ram_cnt_d >= CW'(AF_THRESH));
      ae_d       = (level_d <= CW'(AE_THRESH));
      ovf_d      = wr_en && full_q && !rst;
      udf_d      = rd_en && (ob_cnt_q == 2'd0) && !rst;
   end

   // State registers; reset also discards any RAM data still returning
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q       <= '0;
         rp_q       <= '0;
         ram_cnt_q  <= '0;
         level_q    <= '0;
         ob_cnt_q   <= 2'd0;
         inflight_q <= 1'b0;
         ob0_q      <= '0;
         ob1_q      <= '0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         af_q       <= 1'b0;
         ae_q       <= 1'b1;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         ram_cnt_q  <= ram_cnt_d;
         level_q    <= level_d;
         ob_cnt_q   <= ob_cnt_d;
         inflight_q <= inflight_d;
         ob0_q      <= ob0_d;
         ob1_q      <= ob1_d;
         rd_valid_q <= rd_valid_d;
         full_q     <= full_d;
         af_q       <= af_d;
         ae_q       <= ae_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   // Status outputs straight from flops
   assign full         = full_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign level        = level_q;
   assign ovf          = ovf_q;
   assign udf          = udf_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = ob0_q;

   // RAM port drive; addresses read as zero while reset is held
   assign ram_aw   = rst ? '0 : wp_q;
   assign ram_ar   = rst ? '0 : rp_q;
   assign ram_dw   = wr_data;
   assign ram_cew  = push_acc;
   assign ram_cer  = issue;
   assign ram_rstr = rst;

endmodule
